// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the core's instruction-fetch and data
//   load/store initiators. Both request channels are arbitrated onto one
//   single-port 32-bit word RAM. Each accepted request waits WAIT_CYCLES
//   wait states, performs its access, then returns a one-cycle acknowledge
//   carrying read data or an error flag. Only one access is in flight.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level) and byte address
//   if_ack/if_rdata/if_err   fetch completion pulse, word, out-of-range flag
//   d_req/d_we/d_size     data request, store select, size (byte/half/word)
//   d_addr/d_wdata        data byte address, right-aligned store data
//   d_ack/d_rdata/d_err   data completion pulse, zero-extended load data,
//                         misaligned / out-of-range / reserved-size flag
module mem_responder #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r;
  logic [1:0]  streak_r;
  logic        sel_d_r;
  logic        we_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        grant_d_s;
  logic        grant_f_s;
  logic        access_s;

  logic [AW-1:0] idx_s;
  logic          oor_s;
  logic          misalign_s;
  logic          err_s;
  logic [31:0]   word_s;
  logic [31:0]   shift_s;
  logic [31:0]   load_s;
  logic [3:0]    be_s;
  logic [31:0]   lanes_s;
  logic          write_s;

  logic [31:0] mem [DEPTH];

  // Arbitration and next-state decode. Data wins unless it has already
  // taken two grants in a row while fetch was waiting.
  always_comb begin
    state_s   = state_r;
    grant_d_s = 1'b0;
    grant_f_s = 1'b0;
    access_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (d_req && (streak_r < 2'd2)) begin
          grant_d_s = 1'b1;
          state_s   = S_WAIT;
        end else if (if_req) begin
          grant_f_s = 1'b1;
          state_s   = S_WAIT;
        end else if (d_req) begin
          grant_d_s = 1'b1;
          state_s   = S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          access_s = 1'b1;
          state_s  = S_RESP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Request latch, wait counter and data-streak counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= 4'd0;
      streak_r <= 2'd0;
      sel_d_r  <= 1'b0;
      we_r     <= 1'b0;
      size_r   <= 2'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
    end else if (grant_d_s) begin
      cnt_r   <= 4'(WAIT_CYCLES);
      sel_d_r <= 1'b1;
      we_r    <= d_we;
      size_r  <= d_size;
      addr_r  <= d_addr;
      wdata_r <= d_wdata;
      // Only a grant that overtook a waiting fetch extends the streak.
      if (if_req) streak_r <= (streak_r == 2'd2) ? 2'd2 : streak_r + 2'd1;
      else        streak_r <= 2'd0;
    end else if (grant_f_s) begin
      cnt_r    <= 4'(WAIT_CYCLES);
      sel_d_r  <= 1'b0;
      we_r     <= 1'b0;
      size_r   <= 2'd2;
      addr_r   <= if_addr;
      wdata_r  <= 32'd0;
      streak_r <= 2'd0;
    end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Access decode from the latched request: range/alignment checks, load
  // lane extraction and store byte enables.
  always_comb begin
    idx_s      = addr_r[AW+1:2];
    oor_s      = |addr_r[31:AW+2];
    misalign_s = sel_d_r && (((size_r == 2'b01) && addr_r[0]) ||
                             ((size_r == 2'b10) && (addr_r[1:0] != 2'b00)) ||
                             (size_r == 2'b11));
    err_s      = oor_s || misalign_s;
    word_s     = mem[idx_s];
    // Valid halfwords have addr[0]=0, so a byte-granular shift covers both.
    shift_s    = word_s >> {addr_r[1:0], 3'b000};
    load_s     = 32'd0;
    be_s       = 4'b0000;
    lanes_s    = 32'd0;
    case (size_r)
      2'b00: begin
        load_s  = {24'd0, shift_s[7:0]};
        be_s    = 4'b0001 << addr_r[1:0];
        lanes_s = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        load_s  = {16'd0, shift_s[15:0]};
        be_s    = 4'b0011 << {addr_r[1], 1'b0};
        lanes_s = {2{wdata_r[15:0]}};
      end
      2'b10: begin
        load_s  = word_s;
        be_s    = 4'b1111;
        lanes_s = wdata_r;
      end
      default: begin
        load_s  = 32'd0;
        be_s    = 4'b0000;
        lanes_s = 32'd0;
      end
    endcase
    write_s = access_s && sel_d_r && we_r && !err_s && !rst;
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (write_s && be_s[b]) mem[idx_s][8*b +: 8] <= lanes_s[8*b +: 8];
    end
  end

  // Response registers: non-zero only in the single ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= 32'd0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= 32'd0;
    end else begin
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= 32'd0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= 32'd0;
      if (access_s) begin
        if (sel_d_r) begin
          d_ack   <= 1'b1;
          d_err   <= err_s;
          d_rdata <= (err_s || we_r) ? 32'd0 : load_s;
        end else begin
          if_ack   <= 1'b1;
          if_err   <= oor_s;
          if_rdata <= oor_s ? 32'd0 : word_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Self-checking bench for mem_responder. A word-array reference model with
//   byte arithmetic predicts every response; directed cases, randomized
//   traffic, arbitration fairness, reset abort and zero-wait latency are
//   checked. A second instance runs with WAIT_CYCLES=0.
module tb_mem_responder;

  localparam int W   = 1;
  localparam int LAT = W + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;

  logic        if_req2, if_ack2, if_err2;
  logic [31:0] if_addr2, if_rdata2;
  logic        d_req2, d_we2, d_ack2, d_err2;
  logic [1:0]  d_size2;
  logic [31:0] d_addr2, d_wdata2, d_rdata2;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err)
  );

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_rdata(if_rdata2), .if_err(if_err2),
    .d_req(d_req2), .d_we(d_we2), .d_size(d_size2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_ack(d_ack2), .d_rdata(d_rdata2), .d_err(d_err2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  // Reference data access: byte-wise little-endian over a word array.
  function automatic void model_data(input logic we, input logic [1:0] size,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rd);
    int off, w, nbytes;
    off = int'(addr % 32'd4);
    w   = int'((addr / 32'd4) % 32'd256);
    err = (addr >= 32'd1024) || (size == 2'd3) ||
          ((size == 2'd1) && (off % 2 != 0)) || ((size == 2'd2) && (off != 0));
    rd  = 32'd0;
    if (!err) begin
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      for (int i = 0; i < nbytes; i++) begin
        if (we) ref_mem[w][8*(off+i) +: 8] = wdata[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[w][8*(off+i) +: 8];
      end
    end
  endfunction

  task automatic data_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n;
    model_data(we, size, addr, wdata, exp_err, exp_rd);
    d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    @(negedge clk);
    n = 1;
    // Already accepted: scramble the fields, they must be ignored now.
    d_addr = $urandom; d_wdata = $urandom; d_we = ~we; d_size = ~size;
    while (!d_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("d_latency", 32'(n), 32'(LAT));
    check_eq("d_err", {31'd0, d_err}, {31'd0, exp_err});
    check_eq("d_rdata", d_rdata, exp_rd);
    check_eq("d_no_if_ack", {31'd0, if_ack}, 32'd0);
    got   = d_rdata;
    d_req = 1'b0;
    @(negedge clk);
    check_eq("d_ack_width", {31'd0, d_ack}, 32'd0);
  endtask

  task automatic fetch_txn(input logic [31:0] addr, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n;
    exp_err = (addr >= 32'd1024);
    exp_rd  = exp_err ? 32'd0 : ref_mem[int'((addr / 32'd4) % 32'd256)];
    if_addr = addr; if_req = 1'b1;
    @(negedge clk);
    n = 1;
    if_addr = $urandom;
    while (!if_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("if_latency", 32'(n), 32'(LAT));
    check_eq("if_err", {31'd0, if_err}, {31'd0, exp_err});
    check_eq("if_rdata", if_rdata, exp_rd);
    check_eq("if_no_d_ack", {31'd0, d_ack}, 32'd0);
    got    = if_rdata;
    if_req = 1'b0;
    @(negedge clk);
    check_eq("if_ack_width", {31'd0, if_ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, addr_v, saved;
    logic        we_v;
    logic [1:0]  size_v;
    int          k, cyc, n;

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = 32'd0; d_wdata = 32'd0;
    if_req2 = 1'b0; if_addr2 = 32'd0;
    d_req2 = 1'b0; d_we2 = 1'b0; d_size2 = 2'd0; d_addr2 = 32'd0; d_wdata2 = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check_eq("rst_errs", {30'd0, if_err, d_err}, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_dut0_acks", {30'd0, if_ack2, d_ack2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Give the words used below known contents.
    for (int i = 0; i < 16; i++) data_txn(1'b1, 2'd2, 32'(i * 4), $urandom, got);

    // Directed cases.
    data_txn(1'b1, 2'd2, 32'h0C, 32'hDEADBEEF, got);
    fetch_txn(32'h0C, got);
    check_eq("fetch_word3", got, 32'hDEADBEEF);
    data_txn(1'b1, 2'd0, 32'h0D, 32'h000000A5, got);
    check_eq("store_rdata_zero", got, 32'd0);
    data_txn(1'b0, 2'd2, 32'h0C, 32'd0, got);
    check_eq("load_word_after_byte", got, 32'hDEADA5EF);
    data_txn(1'b0, 2'd1, 32'h0E, 32'd0, got);
    check_eq("load_half_0e", got, 32'h0000DEAD);
    data_txn(1'b0, 2'd0, 32'h0F, 32'd0, got);
    check_eq("load_byte_0f", got, 32'h000000DE);
    data_txn(1'b0, 2'd2, 32'h0E, 32'd0, got);
    data_txn(1'b1, 2'd1, 32'h0D, 32'h0000FFFF, got);
    data_txn(1'b0, 2'd2, 32'h0C, 32'd0, got);
    check_eq("misaligned_store_no_write", got, 32'hDEADA5EF);
    data_txn(1'b0, 2'd2, 32'h400, 32'd0, got);
    data_txn(1'b0, 2'd3, 32'h08, 32'd0, got);
    data_txn(1'b1, 2'd2, 32'h0000_0404, 32'h12345678, got);
    fetch_txn(32'h8000_0000, got);
    fetch_txn(32'h0E, got);

    // Randomized traffic over a small window plus occasional out-of-range bits.
    for (int t = 0; t < 60; t++) begin
      addr_v = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) addr_v = addr_v | (32'd1 << $urandom_range(10, 31));
      if ($urandom_range(0, 2) == 0) begin
        fetch_txn(addr_v, got);
      end else begin
        we_v   = 1'($urandom_range(0, 1));
        size_v = 2'($urandom_range(0, 3));
        data_txn(we_v, size_v, addr_v, $urandom, got);
      end
    end

    // Both channels requesting continuously: two data grants, then a fetch.
    d_we = 1'b0; d_size = 2'd2; d_addr = 32'h0C; if_addr = 32'h10;
    d_req = 1'b1; if_req = 1'b1;
    k = 0; cyc = 0;
    while (k < 9 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      check_eq("no_ack_overlap", {31'd0, d_ack & if_ack}, 32'd0);
      if (d_ack || if_ack) begin
        check_eq("arb_order", {31'd0, if_ack}, (k % 3 == 2) ? 32'd1 : 32'd0);
        k++;
      end
    end
    check_eq("arb_ack_count", 32'(k), 32'd9);
    d_req = 1'b0; if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the wait state of a store aborts it.
    saved = ref_mem[0];
    d_we = 1'b1; d_size = 2'd2; d_addr = 32'h0; d_wdata = 32'h11223344; d_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    check_eq("abort_outputs", {28'd0, if_ack, d_ack, if_err, d_err}, 32'd0);
    check_eq("abort_rdata", if_rdata | d_rdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("abort_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
    end
    data_txn(1'b0, 2'd2, 32'h0, 32'd0, got);
    check_eq("abort_mem_kept", got, saved);

    // Zero wait states: ack two cycles after the request, then every three.
    if_addr2 = 32'h0C; if_req2 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_ack2 && n < 20);
    check_eq("w0_latency", 32'(n), 32'd2);
    check_eq("w0_if_err", {31'd0, if_err2}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!if_ack2 && n < 20);
      check_eq("w0_back_to_back", 32'(n), 32'd3);
    end
    if_req2 = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
